// File: rtl/caravel.sv
// Boot-from-flash runner game: SPI boot read selects enable,
// then a jump/obstacle game is shown on the user GPIO pads.
module caravel #(
  parameter int          TICK_DIV  = 10000,
  parameter logic [23:0] BOOT_ADDR = 24'h000000
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire [37:0] mprj_io,
  inout  wire        gpio,
  output logic       flash_csb,
  output logic       flash_clk,
  output logic       flash_io0,
  input  logic       flash_io1
);

  typedef enum logic [1:0] {B_START, B_XFER, B_DONE} boot_t;
  typedef enum logic [1:0] {G_IDLE, G_RUN, G_OVER} game_t;

  boot_t       bst;
  game_t       gst;
  logic [31:0] tx;
  logic [7:0]  rx;
  logic [5:0]  bcnt;
  logic        en;

  logic [2:0]  s_rst, s_jmp, s_dsp;
  logic        p_rst, p_jmp, p_dsp;
  logic [31:0] tcnt;
  logic        tick;

  logic [7:0]  score, hs;
  logic [4:0]  ox;
  logic [2:0]  height;
  logic        dir_up, jumping, dmode;
  logic        running, game_over;

  logic [4:0]  nx_ox;
  logic [7:0]  nx_score;
  logic [2:0]  nx_h;
  logic        nx_up, nx_jmp, jmp_act, hit;

  logic [30:0] io_out;
  logic        unused_io;

  // SPI mode-0 boot read: 0x03 + address out, one config byte in
  always_ff @(posedge clock) begin
    if (reset) begin
      bst       <= B_START;
      flash_csb <= 1'b1;
      flash_clk <= 1'b0;
      flash_io0 <= 1'b0;
      tx        <= {8'h03, BOOT_ADDR};
      rx        <= 8'h00;
      bcnt      <= 6'd0;
      en        <= 1'b0;
    end else begin
      case (bst)
        B_START: begin
          flash_csb <= 1'b0;
          flash_io0 <= tx[31];
          tx        <= {tx[30:0], 1'b0};
          bst       <= B_XFER;
        end
        B_XFER: begin
          if (!flash_clk) begin
            flash_clk <= 1'b1;
            bcnt      <= bcnt + 6'd1;
            if (bcnt >= 6'd32)
              rx <= {rx[6:0], flash_io1};
          end else begin
            flash_clk <= 1'b0;
            if (bcnt == 6'd40) begin
              flash_csb <= 1'b1;
              flash_io0 <= 1'b0;
              en        <= rx[0];
              bst       <= B_DONE;
            end else begin
              flash_io0 <= tx[31];
              tx        <= {tx[30:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

  // two-flop synchronizers plus one edge-detect flop per button
  always_ff @(posedge clock) begin
    if (reset) begin
      s_rst <= 3'b000;
      s_jmp <= 3'b000;
      s_dsp <= 3'b000;
    end else begin
      s_rst <= {s_rst[1:0], mprj_io[0]};
      s_jmp <= {s_jmp[1:0], mprj_io[5]};
      s_dsp <= {s_dsp[1:0], mprj_io[6]};
    end
  end

  assign p_rst = s_rst[1] & ~s_rst[2];
  assign p_jmp = s_jmp[1] & ~s_jmp[2];
  assign p_dsp = s_dsp[1] & ~s_dsp[2];

  assign tick = (tcnt == 32'(TICK_DIV - 1));

  // free-running game tick divider, restarted by a game reset
  always_ff @(posedge clock) begin
    if (reset || p_rst)
      tcnt <= 32'd0;
    else if (tick)
      tcnt <= 32'd0;
    else
      tcnt <= tcnt + 32'd1;
  end

  // per-tick position, score and jump arc update
  always_comb begin
    jmp_act  = jumping | (p_jmp & (height == 3'd0));
    nx_ox    = (ox == 5'd0) ? 5'd31 : ox - 5'd1;
    nx_score = score;
    if (ox == 5'd0 && score != 8'hff)
      nx_score = score + 8'd1;
    nx_h     = height;
    nx_up    = dir_up;
    nx_jmp   = jmp_act;
    if (jmp_act) begin
      if (dir_up) begin
        nx_h  = height + 3'd1;
        nx_up = (height != 3'd6);
      end else begin
        nx_h = height - 3'd1;
        if (height == 3'd1) begin
          nx_jmp = 1'b0;
          nx_up  = 1'b1;
        end
      end
    end
    hit = (nx_ox == 5'd2) && (nx_h < 3'd3);
  end

  // game state machine
  always_ff @(posedge clock) begin
    if (reset) begin
      gst     <= G_IDLE;
      score   <= 8'd0;
      hs      <= 8'd0;
      ox      <= 5'd31;
      height  <= 3'd0;
      dir_up  <= 1'b1;
      jumping <= 1'b0;
      dmode   <= 1'b0;
    end else if (p_rst) begin
      gst     <= G_IDLE;
      score   <= 8'd0;
      ox      <= 5'd31;
      height  <= 3'd0;
      dir_up  <= 1'b1;
      jumping <= 1'b0;
    end else begin
      if (p_dsp)
        dmode <= ~dmode;
      case (gst)
        G_IDLE: begin
          if (en && p_jmp)
            gst <= G_RUN;
        end
        G_RUN: begin
          jumping <= tick ? nx_jmp : jmp_act;
          if (tick) begin
            ox     <= nx_ox;
            score  <= nx_score;
            height <= nx_h;
            dir_up <= nx_up;
            if (hit) begin
              gst <= G_OVER;
              if (score > hs)
                hs <= score;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign running   = (gst == G_RUN);
  assign game_over = (gst == G_OVER);

  assign io_out = {10'd0, en, dmode, running, game_over,
                   height, ox, (dmode ? hs : score), en};

  assign gpio          = en;
  assign mprj_io[37:7] = en ? io_out : {31{1'bz}};

  assign unused_io = ^{mprj_io[37:7], mprj_io[4:1]};

endmodule

// File: tb/tb_caravel.sv
// Directed bench for caravel: flash boot model plus
// hand-computed game scenarios.
module tb_caravel;

  localparam int TD = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flash_io1 = 1'b0;
  logic flash_csb, flash_clk, flash_io0;
  wire  [37:0] mprj_io;
  wire  gpio;

  logic btn_rst = 1'b0;
  logic btn_jmp = 1'b0;
  logic btn_dsp = 1'b0;
  logic strap   = 1'b1;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  cfg = 8'h00;
  logic [31:0] cmd = 32'd0;
  int          nrise = 0;
  int          nedge = 0;
  logic        pck  = 1'b0;
  logic        pcsb = 1'b1;

  assign mprj_io[0] = btn_rst;
  assign mprj_io[3] = strap;
  assign mprj_io[5] = btn_jmp;
  assign mprj_io[6] = btn_dsp;

  for (genvar i = 7; i < 38; i++) begin : g_pu
    pullup (mprj_io[i]);
  end

  wire [7:0] disp_w = mprj_io[15:8];
  wire [4:0] ox_w   = mprj_io[20:16];
  wire [2:0] h_w    = mprj_io[23:21];

  caravel #(.TICK_DIV(TD), .BOOT_ADDR(24'h000000)) dut (
    .clock     (clock),
    .reset     (reset),
    .mprj_io   (mprj_io),
    .gpio      (gpio),
    .flash_csb (flash_csb),
    .flash_clk (flash_clk),
    .flash_io0 (flash_io0),
    .flash_io1 (flash_io1)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!flash_csb && pcsb) begin
      nrise = 0;
      nedge = 0;
      cmd   = 32'd0;
    end
    if ((!flash_csb || !pcsb) && flash_clk != pck) begin
      nedge++;
      if (flash_clk) begin
        if (nrise < 32)
          cmd = {cmd[30:0], flash_io0};
        nrise++;
      end else if (nrise >= 32 && nrise < 40) begin
        flash_io1 = cfg[39 - nrise];
      end
    end
    pcsb = flash_csb;
    pck  = flash_clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input int which);
    @(negedge clock);
    if (which == 0) btn_rst = 1'b1;
    if (which == 5) btn_jmp = 1'b1;
    if (which == 6) btn_dsp = 1'b1;
    if (which == 9) begin
      btn_rst = 1'b1;
      btn_dsp = 1'b1;
    end
    @(negedge clock);
    btn_rst = 1'b0;
    btn_jmp = 1'b0;
    btn_dsp = 1'b0;
    tick_n(3);
  endtask

  task automatic wait_csb(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (flash_csb) break;
    end
    chk(tag, 32'(flash_csb), 32'd1);
    @(negedge clock);
    #1;
  endtask

  task automatic wait_ox(input string tag,
                         input logic [4:0] v,
                         input int lim);
    for (int i = 0; i < lim; i++) begin
      @(posedge clock);
      #1;
      if (ox_w == v) break;
    end
    chk(tag, 32'(ox_w), 32'(v));
  endtask

  task automatic wait_go(input string tag, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(posedge clock);
      #1;
      if (mprj_io[24] === 1'b1) break;
    end
    chk(tag, 32'(mprj_io[24]), 32'd1);
  endtask

  initial begin
    tick_n(3);
    chk("rst_csb", 32'(flash_csb), 32'd1);
    chk("rst_clk", 32'(flash_clk), 32'd0);
    chk("rst_io0", 32'(flash_io0), 32'd0);
    chk("rst_gpio", 32'(gpio), 32'd0);

    @(negedge clock);
    reset = 1'b0;
    tick_n(1);
    chk("boot_csb_low", 32'(flash_csb), 32'd0);
    wait_csb("boot0_done");
    chk("boot0_edges", 32'(nedge), 32'd80);
    chk("boot0_cmd", cmd, 32'h0300_0000);
    chk("boot0_gpio", 32'(gpio), 32'd0);
    chk("boot0_hiz", 32'(mprj_io[37:7]), 32'h7fff_ffff);

    @(negedge clock);
    reset = 1'b1;
    cfg   = 8'h01;
    tick_n(2);
    @(negedge clock);
    reset = 1'b0;
    tick_n(20);
    @(negedge clock);
    reset = 1'b1;
    tick_n(1);
    chk("abort_csb", 32'(flash_csb), 32'd1);
    chk("abort_clk", 32'(flash_clk), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    wait_csb("boot1_done");
    chk("boot1_edges", 32'(nedge), 32'd80);
    chk("boot1_cmd", cmd, 32'h0300_0000);
    chk("boot1_gpio", 32'(gpio), 32'd1);
    chk("boot1_io7", 32'(mprj_io[7]), 32'd1);
    chk("boot1_io27", 32'(mprj_io[27]), 32'd1);
    chk("boot1_hi0", 32'(mprj_io[37:28]), 32'd0);
    tick_n(30);
    chk("csb_stays", 32'(flash_csb), 32'd1);

    press(0);
    chk("grst_ox", 32'(ox_w), 32'd31);
    chk("grst_h", 32'(h_w), 32'd0);
    chk("grst_disp", 32'(disp_w), 32'd0);
    chk("grst_st", 32'(mprj_io[25:24]), 32'd0);

    press(5);
    chk("run_on", 32'(mprj_io[25]), 32'd1);
    wait_ox("ox30", 5'd30, TD + 4);
    tick_n(TD);
    chk("ox29", 32'(ox_w), 32'd29);

    wait_go("go1", 30 * TD);
    chk("go1_ox", 32'(ox_w), 32'd2);
    chk("go1_h", 32'(h_w), 32'd0);
    chk("go1_run", 32'(mprj_io[25]), 32'd0);
    tick_n(5 * TD);
    chk("go1_frz_ox", 32'(ox_w), 32'd2);
    chk("go1_frz_st", 32'(mprj_io[25:24]), 32'd1);
    chk("go1_frz_sc", 32'(disp_w), 32'd0);

    press(0);
    chk("grst2_ox", 32'(ox_w), 32'd31);
    press(5);
    wait_ox("at5", 5'd5, 40 * TD);
    press(5);
    wait_ox("at2", 5'd2, 4 * TD);
    chk("at2_h", 32'(h_w), 32'd3);
    chk("at2_go", 32'(mprj_io[24]), 32'd0);
    wait_ox("wrap", 5'd31, 3 * TD);
    chk("wrap_sc", 32'(disp_w), 32'd1);
    chk("wrap_h", 32'(h_w), 32'd6);

    wait_go("go2", 35 * TD);
    chk("go2_h", 32'(h_w), 32'd0);
    chk("go2_sc", 32'(disp_w), 32'd1);

    press(0);
    chk("grst3_sc", 32'(disp_w), 32'd0);
    press(6);
    chk("dsp1_mode", 32'(mprj_io[26]), 32'd1);
    chk("dsp1_hs", 32'(disp_w), 32'd1);
    press(6);
    chk("dsp2_mode", 32'(mprj_io[26]), 32'd0);
    chk("dsp2_sc", 32'(disp_w), 32'd0);

    press(9);
    chk("prio_mode", 32'(mprj_io[26]), 32'd0);

    @(negedge clock);
    btn_dsp = 1'b1;
    tick_n(10);
    @(negedge clock);
    btn_dsp = 1'b0;
    tick_n(4);
    chk("hold_mode", 32'(mprj_io[26]), 32'd1);
    chk("hold_hs", 32'(disp_w), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/caravel.md
CARAVEL -- requirements
Module: caravel

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 10000: number of clock cycles per game tick.
REQ-002 The block SHALL have parameter BOOT_ADDR, default 24'h000000: flash byte address of the configuration byte.
REQ-003 Port clock, input, 1: the single system clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port mprj_io, inout, 38: user GPIO pads.
- Inputs: bit 0 = game-reset button, bit 3 = CSB strap, bit 5 = jump button, bit 6 = display button.
- Outputs: bits 37:7.
- Bits 4:1 are never driven.
REQ-006 Port gpio, inout, 1: management GPIO, driven with the value of en.
REQ-007 Port flash_csb, output, 1: SPI flash chip select, active low.
REQ-008 Port flash_clk, output, 1: SPI flash clock.
REQ-009 Port flash_io0, output, 1: SPI MOSI.
REQ-010 Port flash_io1, input, 1: SPI MISO.

Function
REQ-011 Boot: one clock after reset deasserts, the block SHALL take flash_csb low and run the boot read.
- SPI mode 0; flash_clk = clock/2.
- Shift out 0x03 then BOOT_ADDR (24 bits), MSB first on flash_io0; change flash_io0 only while flash_clk is low.
- Then sample 8 bits from flash_io1 on flash_clk rising edges, MSB first.
- Then raise flash_csb and hold flash_clk low.
REQ-012 en SHALL equal bit 0 of the configuration byte after boot; en is 0 during boot.
REQ-013 After boot, flash_csb SHALL stay high until the next reset.
REQ-014 While en=0:
- mprj_io[37:7] SHALL be high-Z.
- The game SHALL stay in IDLE.
REQ-015 While en=1, mprj_io[37:7] SHALL be driven as follows:
- [15:8] display value.
- [20:16] obstacle_x.
- [23:21] height.
- [24] game_over.
- [25] running.
- [26] display_mode.
- [27] en.
- [37:28] 0.
- [7] en.
REQ-016 Each button input SHALL pass through a 2-flop synchronizer followed by rising-edge detection.
- Each press produces exactly one pulse.
- A held button produces no further pulses.
REQ-017 A tick counter SHALL count 0..TICK_DIV-1; the tick pulse occurs on wrap. The counter clears on reset and on a game-reset pulse.
REQ-018 The game state machine SHALL have states IDLE, RUN and OVER.
- Reset value is IDLE with score=0, obstacle_x=31, height=0 and vertical direction up.
REQ-019 IDLE: a jump pulse SHALL move the machine to RUN on the next clock.
REQ-020 RUN, on each tick: obstacle_x decrements by 1.
- From 0 it wraps to 31.
- On each wrap, score increments by 1, saturating at 255.
REQ-021 RUN: a jump pulse while height=0 SHALL start a jump.
- Height rises by 1 per tick up to 7, then falls by 1 per tick back to 0.
- Jump pulses while height is nonzero SHALL be ignored.
REQ-022 Collision: if, after a tick update, obstacle_x=2 and height<3, the machine SHALL go to OVER.
- In OVER, game_over=1, running=0, and all positions and score are frozen.
REQ-023 On entry to OVER, high_score SHALL load score if score>high_score.
REQ-024 A game-reset pulse in any state SHALL restore the REQ-018 values.
- It does not change high_score, display_mode or en.
REQ-025 A display pulse SHALL toggle display_mode.
- Display value = score when display_mode=0, high_score when display_mode=1.
REQ-026 Simultaneous pulses SHALL be prioritised: game-reset, then jump, then display.
- Display still toggles in the same cycle unless game-reset is also present.
REQ-027 running SHALL be 1 exactly while in RUN.
REQ-028 mprj_io[3] SHALL be input-only and SHALL have no functional effect.

Reset
REQ-029 While reset=1, the block SHALL set:
- en=0, flash_csb=1, flash_clk=0, flash_io0=0.
- State IDLE, score=0, high_score=0, display_mode=0, obstacle_x=31, height=0, tick counter=0, synchronizers=0.
REQ-030 Asserting reset in mid-operation, including during a flash transfer, SHALL abort that operation and restart boot after release.

Verification
REQ-031 Flash byte at address 0 = 0x01 -> after 80 flash_clk edges flash_csb=1; then mprj_io[7]=1, mprj_io[27]=1 and gpio=1. Flash byte = 0x00 -> mprj_io[37:7] stays high-Z.
REQ-032 en=1, game-reset press (mprj_io[0] high for 1 cycle) -> within 4 clocks: mprj_io[20:16]=31, mprj_io[23:21]=0, mprj_io[15:8]=0, mprj_io[25:24]=0.
REQ-033 Jump press in IDLE -> running=1 within 4 clocks; obstacle_x = 30 after TICK_DIV clocks and 29 after 2*TICK_DIV.
REQ-034 Run with no jump -> obstacle_x reaches 2 at tick 29 with height 0 -> game_over=1; values unchanged 5 ticks later.
REQ-035 Jump press at obstacle_x=5 -> height 3 at x=2, no collision; at wrap 0->31 score=1 on mprj_io[15:8].
REQ-036 After a game over with score=1, game-reset then display press -> mprj_io[26]=1, mprj_io[15:8]=1 (high score); press again -> shows 0.
